// File: rtl/awg_param_ctrl.sv
// Front-panel parameter controller for the AWG: button edges -> edit-field FSM and parameter steps.
// Optional auto-repeat on held up/down buttons is enabled by defining AWG_AUTOREPEAT_EN.
module awg_param_ctrl #(
  parameter int unsigned NUM_WAVES  = 5,
  parameter logic [11:0] FREQ_INIT  = 12'd100,
  parameter logic [11:0] FREQ_MIN   = 12'd1,
  parameter logic [11:0] FREQ_MAX   = 12'd4000,
  parameter logic [11:0] FREQ_STEP  = 12'd10,
  parameter logic [7:0]  PHASE_STEP = 8'd8,
  parameter logic [23:0] HOLD_DLY   = 24'd5000000,
  parameter logic [23:0] RPT_PER    = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        upd_ack,
  output logic [4:0]  state,
  output logic [11:0] state_freq,
  output logic [2:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic [1:0]  edit_sel,
  output logic        upd_req
);

  typedef enum logic [1:0] {
    StWave  = 2'd0,
    StFreq  = 2'd1,
    StAmp   = 2'd2,
    StPhase = 2'd3
  } field_e;

  localparam logic [4:0] LastWave = 5'(NUM_WAVES - 1);

  field_e      field_q, field_d;
  logic        btn_mode_q, btn_up_q, btn_down_q;
  logic [4:0]  state_q, state_d;
  logic [11:0] freq_q, freq_d;
  logic [2:0]  amp_q, amp_d;
  logic [7:0]  phase_q, phase_d;
  logic        upd_req_q, upd_req_d;

  logic        mode_e, up_e, dn_e;
  logic        step_up, step_dn, changed;
  logic        rpt_fire;
  logic [12:0] freq_sum, freq_diff;

  assign mode_e = btn_mode & ~btn_mode_q;
  assign up_e   = btn_up & ~btn_up_q;
  assign dn_e   = btn_down & ~btn_down_q;

`ifdef AWG_AUTOREPEAT_EN
  logic [23:0] hold_cnt_q, hold_cnt_d;

  // After the first repeat the counter is rewound so it next hits HOLD_DLY after RPT_PER cycles.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    rpt_fire   = 1'b0;
    if (!(btn_up ^ btn_down) || mode_e) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q == HOLD_DLY) begin
      rpt_fire   = 1'b1;
      hold_cnt_d = HOLD_DLY - RPT_PER + 24'd1;
    end else begin
      hold_cnt_d = hold_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_rpt_params;
  assign unused_rpt_params = ^{HOLD_DLY, RPT_PER};
  assign rpt_fire = 1'b0;
`endif

  // Mode edge discards any step; simultaneous up/down edges cancel.
  assign step_up = ~mode_e & ((up_e & ~dn_e) | (rpt_fire & btn_up));
  assign step_dn = ~mode_e & ((dn_e & ~up_e) | (rpt_fire & btn_down));

  assign freq_sum  = {1'b0, freq_q} + {1'b0, FREQ_STEP};
  assign freq_diff = {1'b0, freq_q} - {1'b0, FREQ_STEP};

  always_comb begin
    field_d = field_q;
    state_d = state_q;
    freq_d  = freq_q;
    amp_d   = amp_q;
    phase_d = phase_q;

    if (mode_e) begin
      unique case (field_q)
        StWave:  field_d = StFreq;
        StFreq:  field_d = StAmp;
        StAmp:   field_d = StPhase;
        StPhase: field_d = StWave;
        default: field_d = StWave;
      endcase
    end

    if (step_up) begin
      unique case (field_q)
        StWave:  state_d = (state_q == LastWave) ? 5'd0 : state_q + 5'd1;
        StFreq:  freq_d  = (freq_sum > {1'b0, FREQ_MAX}) ? FREQ_MAX : freq_sum[11:0];
        StAmp:   amp_d   = (amp_q == 3'd7) ? 3'd7 : amp_q + 3'd1;
        StPhase: phase_d = phase_q + PHASE_STEP;
        default: ;
      endcase
    end else if (step_dn) begin
      unique case (field_q)
        StWave:  state_d = (state_q == 5'd0) ? LastWave : state_q - 5'd1;
        StFreq:  freq_d  = (freq_diff[12] || (freq_diff[11:0] < FREQ_MIN)) ? FREQ_MIN
                                                                            : freq_diff[11:0];
        StAmp:   amp_d   = (amp_q == 3'd0) ? 3'd0 : amp_q - 3'd1;
        StPhase: phase_d = phase_q - PHASE_STEP;
        default: ;
      endcase
    end

    changed = (state_d != state_q) || (freq_d != freq_q) || (amp_d != amp_q) ||
              (phase_d != phase_q);

    upd_req_d = upd_req_q;
    if (changed) begin
      upd_req_d = 1'b1;
    end else if (upd_ack) begin
      upd_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Load current levels so a button held through reset yields no edge.
      btn_mode_q <= btn_mode;
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      field_q    <= StWave;
      state_q    <= 5'd0;
      freq_q     <= FREQ_INIT;
      amp_q      <= 3'd7;
      phase_q    <= 8'd0;
      upd_req_q  <= 1'b0;
    end else begin
      btn_mode_q <= btn_mode;
      btn_up_q   <= btn_up;
      btn_down_q <= btn_down;
      field_q    <= field_d;
      state_q    <= state_d;
      freq_q     <= freq_d;
      amp_q      <= amp_d;
      phase_q    <= phase_d;
      upd_req_q  <= upd_req_d;
    end
  end

  assign state       = state_q;
  assign state_freq  = freq_q;
  assign state_amp   = amp_q;
  assign state_phase = phase_q;
  assign edit_sel    = field_q;
  assign upd_req     = upd_req_q;

endmodule

// File: tb/tb_awg_param_ctrl.sv
// Directed self-checking bench for awg_param_ctrl; the auto-repeat section runs only when
// AWG_AUTOREPEAT_EN is defined.
module tb_awg_param_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_mode, btn_up, btn_down, upd_ack;
  logic [4:0]  state;
  logic [11:0] state_freq;
  logic [2:0]  state_amp;
  logic [7:0]  state_phase;
  logic [1:0]  edit_sel;
  logic        upd_req;

  int n_cmp = 0;
  int n_err = 0;

  awg_param_ctrl #(
    .HOLD_DLY (24'd10),
    .RPT_PER  (24'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_mode    (btn_mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .upd_ack     (upd_ack),
    .state       (state),
    .state_freq  (state_freq),
    .state_amp   (state_amp),
    .state_phase (state_phase),
    .edit_sel    (edit_sel),
    .upd_req     (upd_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_up();
    btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
  endtask

  task automatic press_dn();
    btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; tick(); btn_mode = 1'b0; tick();
  endtask

  task automatic ack();
    upd_ack = 1'b1; tick(); upd_ack = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; upd_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_state", 32'(state), 0);
    check("rst_freq", 32'(state_freq), 100);
    check("rst_amp", 32'(state_amp), 7);
    check("rst_phase", 32'(state_phase), 0);
    check("rst_edit", 32'(edit_sel), 0);
    check("rst_req", 32'(upd_req), 0);

    // WAVE field wraps 4 -> 0 and 0 -> 4
    press_up(); check("wave_1", 32'(state), 1);
    press_up(); check("wave_2", 32'(state), 2);
    press_up(); check("wave_3", 32'(state), 3);
    press_up(); check("wave_4", 32'(state), 4);
    press_up(); check("wave_wrap0", 32'(state), 0);
    check("wave_req", 32'(upd_req), 1);
    ack(); check("wave_ack", 32'(upd_req), 0);
    press_dn(); check("wave_wrap4", 32'(state), 4);
    press_up(); check("wave_back0", 32'(state), 0);
    ack();

    // Mode-only edge never requests an update
    press_mode();
    check("edit_freq", 32'(edit_sel), 1);
    check("mode_noreq", 32'(upd_req), 0);

    // FREQ saturation at both ends
    for (int i = 0; i < 389; i++) press_up();
    check("freq_3990", 32'(state_freq), 3990);
    press_up(); check("freq_max", 32'(state_freq), 4000);
    ack();
    press_up(); check("freq_max_hold", 32'(state_freq), 4000);
    check("freq_max_noreq", 32'(upd_req), 0);
    for (int i = 0; i < 399; i++) press_dn();
    check("freq_10", 32'(state_freq), 10);
    press_dn(); check("freq_min", 32'(state_freq), 1);
    ack();
    press_dn(); check("freq_min_hold", 32'(state_freq), 1);
    check("freq_min_noreq", 32'(upd_req), 0);

    // AMP saturation
    press_mode(); check("edit_amp", 32'(edit_sel), 2);
    press_up(); check("amp_max", 32'(state_amp), 7);
    check("amp_max_noreq", 32'(upd_req), 0);
    for (int i = 0; i < 7; i++) press_dn();
    check("amp_0", 32'(state_amp), 0);
    press_dn(); check("amp_min", 32'(state_amp), 0);
    ack();

    // PHASE wraps modulo 256
    press_mode(); check("edit_phase", 32'(edit_sel), 3);
    press_dn(); check("phase_wrap248", 32'(state_phase), 248);
    press_up(); check("phase_wrap0", 32'(state_phase), 0);
    press_up(); check("phase_8", 32'(state_phase), 8);
    ack();

    // Mode and up together: field advances, no step
    btn_mode = 1'b1; btn_up = 1'b1; tick();
    btn_mode = 1'b0; btn_up = 1'b0; tick();
    check("mode_up_edit", 32'(edit_sel), 0);
    check("mode_up_state", 32'(state), 0);
    check("mode_up_phase", 32'(state_phase), 8);
    check("mode_up_noreq", 32'(upd_req), 0);

    // Up and down together: no step
    btn_up = 1'b1; btn_down = 1'b1; tick();
    btn_up = 1'b0; btn_down = 1'b0; tick();
    check("updn_state", 32'(state), 0);
    check("updn_noreq", 32'(upd_req), 0);

    // Change coincident with ack keeps the request
    btn_up = 1'b1; upd_ack = 1'b1; tick();
    btn_up = 1'b0; upd_ack = 1'b0; tick();
    check("ack_coinc_state", 32'(state), 1);
    check("ack_coinc_req", 32'(upd_req), 1);

    // Reset with request pending and a button held: no step after release of reset
    btn_up = 1'b1; rst = 1'b1; tick(); tick();
    rst = 1'b0; tick(); tick();
    check("rst_held_state", 32'(state), 0);
    check("rst_held_req", 32'(upd_req), 0);
    btn_up = 1'b0; tick();
    check("rst_rel_state", 32'(state), 0);

`ifdef AWG_AUTOREPEAT_EN
    press_mode(); press_mode();
    for (int i = 0; i < 7; i++) press_dn();
    check("rpt_amp0", 32'(state_amp), 0);
    btn_up = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int steps;
      tick();
      steps = 1 + ((k >= 10) ? (1 + (k - 10) / 4) : 0);
      if (steps > 7) steps = 7;
      check($sformatf("rpt_k%0d", k), 32'(state_amp), 32'(steps));
    end
    btn_up = 1'b0; tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
